// File: rtl/gather_fifo_if.sv
// Handshake bundle between the gather compaction stage, gather_fifo and its single-issue consumer.
// Enable-level signals follow the ACT parameter of the attached gather_fifo.
interface gather_fifo_if #(
  parameter int DATA  = 32,
  parameter int IN    = 4,
  parameter int DEPTH = 16
);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [IN-1:0]           in_valid;
  logic [IN-1:0][DATA-1:0] in_data;
  logic                    in_ready;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA-1:0]         out_data;
  logic [CNTW-1:0]         count;
  logic                    ovfl;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count, ovfl
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count, ovfl
  );
endinterface

// File: rtl/gather_fifo.sv
// Multi-lane enqueue / single-lane dequeue FIFO fed by the gather compaction stage.
// Optional sticky overflow flag enabled by defining GATHER_FIFO_OVFL_EN.
module gather_fifo #(
  parameter int   DATA  = 32,
  parameter int   IN    = 4,
  parameter int   DEPTH = 16,
  parameter logic ACT   = 1'b0
) (
  input  logic clk,
  input  logic reset_,
  gather_fifo_if.slave bus
);
  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [DATA-1:0] mem [DEPTH];
  logic [PTRW-1:0] head;
  logic [PTRW-1:0] tail;
  logic [CNTW-1:0] count;

  logic [IN-1:0]   lane_en;
  logic [PTRW-1:0] wr_addr [IN];
  logic [CNTW-1:0] nwr;
  logic            ready;
  logic            pop;
  logic            not_empty;

  function automatic logic is_on(input logic x);
    return x == ACT;
  endfunction

  function automatic logic drive(input logic on);
    return on ? ACT : ~ACT;
  endfunction

  // Accept is decided from registered occupancy only, so a same-cycle pop never opens the input.
  always_comb begin
    not_empty = (count != '0);
    ready     = ((CNTW'(DEPTH) - count) >= CNTW'(IN));
    pop       = not_empty && is_on(bus.out_ready);
  end

  // Each enabled lane lands at tail plus the number of enabled lanes below it.
  always_comb begin
    nwr     = '0;
    lane_en = '0;
    for (int i = 0; i < IN; i++) begin
      lane_en[i] = is_on(bus.in_valid[i]);
      wr_addr[i] = tail + PTRW'(nwr);
      if (lane_en[i]) nwr = nwr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop)   head <= head + 1'b1;
      if (ready) tail <= tail + PTRW'(nwr);
      count <= count + (ready ? nwr : '0) - CNTW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < IN; i++) begin
      if (ready && lane_en[i]) mem[wr_addr[i]] <= bus.in_data[i];
    end
  end

  assign bus.in_ready  = drive(ready);
  assign bus.out_valid = drive(not_empty);
  assign bus.out_data  = not_empty ? mem[head] : '0;
  assign bus.count     = count;

`ifdef GATHER_FIFO_OVFL_EN
  logic ovfl_q;
  logic ovfl_set;

  assign ovfl_set = (|lane_en) && !ready;

  always_ff @(posedge clk) begin
    if (!reset_)       ovfl_q <= 1'b0;
    else if (ovfl_set) ovfl_q <= 1'b1;
  end

  assign bus.ovfl = drive(ovfl_q);

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_) !ovfl_set)
    else $error("gather_fifo: write presented while not ready");
`else
  assign bus.ovfl = drive(1'b0);
`endif
endmodule
